rr_decoder_arbiter: RTL
=======================

Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter that shares one 3-to-8 enabled decoder among 8 requesters.
- Picks a requester, drives the decoder select lines sel_a/sel_b/sel_c (sel_a = MSB) plus the enable sel_e, and holds the grant until the requester finishes.
- After each grant it inserts a break-before-make gap, so two decoder outputs are never active on consecutive cycles without an idle cycle between them.
- Sits between requesting units and the decoder; grant is the decoded one-hot copy for local use.

Parameters:
- GAP_CYCLES, 1, number of cycles sel_e is held 0 after a release, legal range 1..15.
- MAX_HOLD, 16, maximum cycles a grant may last; used only with GRANT_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  in  1  single clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  8  request vector; bit i is requester i; level-sensitive.
- done  in  1  one-cycle pulse from the current owner; ends the grant.
- sel_e  out  1  decoder enable; 1 only in GRANT state.
- sel_a  out  1  decoder select bit 2 (MSB of index).
- sel_b  out  1  decoder select bit 1.
- sel_c  out  1  decoder select bit 0.
- grant  out  8  one-hot; grant[idx] = sel_e; all zero when sel_e = 0.
- busy  out  1  1 in GRANT or GAP.
- timeout  out  1  one-cycle pulse when a grant is force-released; tied 0 without GRANT_TIMEOUT_EN.

Behaviour:
- Reset (async, reset_n = 0):
  - Outputs: sel_e=0, sel_a/b/c=0, grant=0, busy=0, timeout=0.
  - Internal: ptr=0, state=IDLE, counters=0.
  - Reset mid-grant drops grant immediately, without waiting for a clock.
- All outputs are registered; grant is decoded from the registered index and sel_e.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0 at a clk edge, select the first set bit searching from ptr upward, wrapping 7 -> 0.
  - Load idx, set sel_e=1, go to GRANT.
  - Latency: req sampled at edge k; grant visible after edge k.
- GRANT release conditions: done=1, or req[idx]=0, or hold counter reaches MAX_HOLD (only with the macro).
- On release:
  - sel_e=0; sel_a/b/c keep their last value.
  - ptr = idx+1 mod 8.
  - Load gap counter, go to GAP.
- Simultaneous done and req[idx] fall: a single release.
- Timeout coinciding with done: treated as a normal release; timeout stays 0.
- done outside GRANT: ignored.
- GAP:
  - Count GAP_CYCLES cycles with sel_e=0, then go to IDLE.
  - Requests seen during GAP are not granted until IDLE evaluates them.
  - Minimum grant-to-grant spacing is GAP_CYCLES+1 cycles.
- Fairness: the requester just released has the lowest priority at the next arbitration; the worst-case wait is 7 grants.
- req bits other than idx changing during GRANT: no effect.
- ptr wrap-around: idx=7 released -> ptr=0.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on grant and increments each GRANT cycle.
  - When the counter equals MAX_HOLD-1 and no other release condition holds, release at that edge: timeout pulses 1 for one cycle, and ptr advances as a normal release.
- When undefined: no counter logic; a grant lasts indefinitely while req[idx]=1 and done=0; timeout is tied 0.

Decomposition:
- Shared package (dec_arb_pkg):
  - state encoding IDLE=2'd0, GRANT=2'd1, GAP=2'd2;
  - constant NUM_REQ=8;
  - constant IDX_W=3.
- Sub-module dec3to8_onehot: combinational index+enable -> one-hot, used to form grant.
- Round-robin priority search stays in the top as a function.

Test Plan:
- Reset held, req=8'hFF -> grant=0, sel_e=0; release reset, first edge -> idx=0, sel_a/b/c=000, grant=8'h01.
- req=8'hFF, done pulsed every 3rd cycle -> grants in order 0,1,...,7,0; each separated by 1 cycle with sel_e=0 (GAP_CYCLES=1).
- req=8'h90 with ptr=5 -> grant 7 (sel_a/b/c=111), then 4, then 7 again; wrap-around verified.
- req[idx] dropped in the same cycle as done -> exactly one release, ptr=idx+1, no double advance.
- reset_n pulled low mid-GRANT between edges -> grant=0 immediately; after release, arbitration restarts from ptr=0.
- GRANT_TIMEOUT_EN, MAX_HOLD=4, req=8'h01 held, done never asserted -> sel_e high 4 cycles, timeout pulse, GAP, then grant 0 again.

Source files
------------

// File: rtl/dec_arb_pkg.sv
// Shared types and constants for the round-robin decoder arbiter.
package dec_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

endpackage

// File: rtl/dec3to8_onehot.sv
// Combinational 3-to-8 decoder with enable; output is one-hot, or all zero when disabled.
module dec3to8_onehot
  import dec_arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  input  logic               en,
  output logic [NUM_REQ-1:0] onehot
);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
    assign onehot[gi] = en && (idx == IDX_W'(gi));
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoder among 8 requesters, with a break-before-make gap.
// Optional forced release after MAX_HOLD cycles when GRANT_TIMEOUT_EN is defined.
module rr_decoder_arbiter
  import dec_arb_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic               sel_e,
  output logic               sel_a,
  output logic               sel_b,
  output logic               sel_c,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout
);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("rr_decoder_arbiter: GAP_CYCLES or MAX_HOLD out of range");
  end

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [3:0]       gap_cnt_reg, gap_cnt_next;
  logic             sel_e_reg, sel_e_next;
  logic             busy_reg, busy_next;
  logic             hold_hit;
  logic             rel_now;
  logic             arbitrate;

  // First set bit at or above p, wrapping 7 -> 0; the smallest offset wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] cand;
    rr_pick = p;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = p + IDX_W'(k);
      if (r[cand]) rr_pick = cand;
    end
  endfunction

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    ptr_next     = ptr_reg;
    gap_cnt_next = gap_cnt_reg;
    rel_now      = 1'b0;
    arbitrate    = 1'b0;

    case (state_reg)
      IDLE: arbitrate = 1'b1;
      GRANT: begin
        rel_now = done || !req[idx_reg] || hold_hit;
        if (rel_now) begin
          state_next   = GAP;
          ptr_next     = idx_reg + IDX_W'(1);
          gap_cnt_next = GAP_LOAD;
        end
      end
      GAP: begin
        // The last gap cycle evaluates requests as IDLE would, so back-to-back
        // grants are separated by exactly GAP_CYCLES disabled cycles.
        if (gap_cnt_reg <= 4'd1) begin
          arbitrate    = 1'b1;
          gap_cnt_next = 4'd0;
        end else begin
          gap_cnt_next = gap_cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (arbitrate) begin
      if (|req) begin
        state_next = GRANT;
        idx_next   = rr_pick(req, ptr_reg);
      end else begin
        state_next = IDLE;
      end
    end

    sel_e_next = (state_next == GRANT);
    busy_next  = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      ptr_reg     <= '0;
      gap_cnt_reg <= '0;
      sel_e_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      ptr_reg     <= ptr_next;
      gap_cnt_reg <= gap_cnt_next;
      sel_e_reg   <= sel_e_next;
      busy_reg    <= busy_next;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_reg;
  logic       timeout_reg;
  logic       tmo_fire;

  assign hold_hit = (hold_cnt_reg == HOLD_LAST);
  // Only a release caused solely by the hold limit reports a timeout.
  assign tmo_fire = (state_reg == GRANT) && hold_hit && !done && req[idx_reg];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      hold_cnt_reg <= (state_reg == GRANT) ? hold_cnt_reg + 8'd1 : 8'd0;
      timeout_reg  <= tmo_fire;
    end
  end

  assign timeout = timeout_reg;
`else
  assign hold_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign sel_e = sel_e_reg;
  assign sel_a = idx_reg[2];
  assign sel_b = idx_reg[1];
  assign sel_c = idx_reg[0];
  assign busy  = busy_reg;

  dec3to8_onehot u_dec (
    .idx    (idx_reg),
    .en     (sel_e_reg),
    .onehot (grant)
  );

endmodule
